// File: rtl/signed_pipe_addsub_pkg.sv
// -----------------------------------------------------------------------------
// signed_pipe_addsub_pkg
// Shared definitions for the pipelined signed adder/subtractor:
//   OP_ADD / OP_SUB : encodings of the op_sub mode bit
//   sat_limit()     : saturation value (MAX or MIN) for a given width
//   ovf()           : signed overflow from the carries around the MSB
// -----------------------------------------------------------------------------
package signed_pipe_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest result sat_limit can describe; callers truncate to their width.
    localparam int LIMIT_W = 64;

    // Returns 0x7F..F (negative=0) or 0x80..0 (negative=1) in the low
    // 'width' bits of the result.
    function automatic logic [LIMIT_W-1:0] sat_limit(input int width, input logic negative);
        logic [LIMIT_W-1:0] msb_only;
        msb_only = LIMIT_W'(1) << (width - 1);
        return negative ? msb_only : (msb_only - LIMIT_W'(1));
    endfunction

    // Signed overflow: carry into the MSB differs from carry out of it.
    function automatic logic ovf(input logic cin_msb, input logic cout_msb);
        return cin_msb ^ cout_msb;
    endfunction

endpackage

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder cell.
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/signed_seg_adder.sv
// -----------------------------------------------------------------------------
// signed_seg_adder
// SEG-bit ripple-carry segment built from full_adder cells.
//   a_seg, b_seg : segment operands (b_seg already inverted for subtract)
//   cin          : carry into bit 0 of the segment
//   sum_seg      : segment sum
//   cout         : carry out of the segment MSB
//   cin_msb      : carry into the segment MSB (used for overflow detection
//                  when this is the top segment of the word)
// -----------------------------------------------------------------------------
module signed_seg_adder #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a_seg,
    input  logic [SEG-1:0] b_seg,
    input  logic           cin,
    output logic [SEG-1:0] sum_seg,
    output logic           cout,
    output logic           cin_msb
);

    // w_carry[i] is the carry into bit i; w_carry[SEG] leaves the segment.
    logic [SEG:0] w_carry;

    assign w_carry[0] = cin;

    generate
        for (genvar gi = 0; gi < SEG; gi++) begin : gen_bit
            full_adder u_fa (
                .a    (a_seg[gi]),
                .b    (b_seg[gi]),
                .cin  (w_carry[gi]),
                .s    (sum_seg[gi]),
                .cout (w_carry[gi+1])
            );
        end
    endgenerate

    assign cout    = w_carry[SEG];
    assign cin_msb = w_carry[SEG-1];

endmodule

// File: rtl/signed_pipe_addsub.sv
// -----------------------------------------------------------------------------
// signed_pipe_addsub
// Pipelined signed adder/subtractor with optional saturation. The word is
// split into SEG-bit segments; stage k resolves segment k using the carry
// registered by stage k-1. Latency is STAGES = WIDTH/SEG cycles, throughput
// one beat per cycle. Stall is global: every register holds when the output
// beat is not being taken.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready depends only on the
//                         output side)
//   a, b                : signed operands
//   op_sub              : 0 = a+b, 1 = a-b
//   sat_en              : clamp the result on signed overflow
//   out_valid/out_ready : result handshake
//   sum                 : wrapped or saturated result
//   overflow            : signed overflow of the unsaturated operation
//   cout                : raw carry out of the MSB (subtract: 1 = no borrow)
// WIDTH must be >= 2 and an integer multiple of SEG.
// -----------------------------------------------------------------------------
module signed_pipe_addsub
    import signed_pipe_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             overflow,
    output logic             cout
);

    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;

    // Stage k registers hold the operands of a beat waiting for segment k to
    // be resolved. r_res carries the already-resolved low segments (zeros
    // above them); r_b is the effective B, so the mode's arithmetic effect
    // travels in r_b and r_carry while sat_en rides explicitly.
    logic             r_valid [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic [WIDTH-1:0] r_res   [STAGES];
    logic             r_carry [STAGES];
    logic             r_sat   [STAGES];

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_overflow;
    logic             r_cout;

    logic [SEG-1:0]   w_seg_sum     [STAGES];
    logic             w_seg_cout    [STAGES];
    logic             w_seg_cin_msb [STAGES];
    logic [WIDTH-1:0] w_res_next    [STAGES];

    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_ovf;
    logic             w_negative;
    logic [WIDTH-1:0] w_final_sum;

    // Lock-step pipeline: everything moves unless a finished beat is stuck.
    assign w_advance = !r_out_valid || out_ready;
    assign in_ready  = w_advance;

    assign w_b_eff = (op_sub == OP_ADD) ? b : ~b;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
            signed_seg_adder #(
                .SEG (SEG)
            ) u_seg (
                .a_seg   (r_a[gi][gi*SEG +: SEG]),
                .b_seg   (r_b[gi][gi*SEG +: SEG]),
                .cin     (r_carry[gi]),
                .sum_seg (w_seg_sum[gi]),
                .cout    (w_seg_cout[gi]),
                .cin_msb (w_seg_cin_msb[gi])
            );

            // Segment gi of r_res is still zero, so OR-ing places the new bits.
            assign w_res_next[gi] = r_res[gi] | (WIDTH'(w_seg_sum[gi]) << (gi * SEG));
        end
    endgenerate

    // Final stage: overflow from the carries around the word MSB. Overflow
    // only happens when both operands share a sign, so A's MSB gives the
    // direction of the clamp.
    assign w_ovf       = ovf(w_seg_cin_msb[LAST], w_seg_cout[LAST]);
    assign w_negative  = r_a[LAST][WIDTH-1];
    assign w_final_sum = (r_sat[LAST] && w_ovf) ? WIDTH'(sat_limit(WIDTH, w_negative))
                                                : w_res_next[LAST];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_res[k]   <= '0;
                r_carry[k] <= 1'b0;
                r_sat[k]   <= 1'b0;
            end
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_overflow  <= 1'b0;
            r_cout      <= 1'b0;
        end else if (w_advance) begin
            // Data registers only load behind a valid beat so that bubbles
            // leave the last result visible on sum/overflow/cout.
            r_valid[0] <= in_valid;
            if (in_valid) begin
                r_a[0]     <= a;
                r_b[0]     <= w_b_eff;
                r_res[0]   <= '0;
                r_carry[0] <= (op_sub == OP_SUB);
                r_sat[0]   <= sat_en;
            end

            for (int k = 1; k < STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
                if (r_valid[k-1]) begin
                    r_a[k]     <= r_a[k-1];
                    r_b[k]     <= r_b[k-1];
                    r_res[k]   <= w_res_next[k-1];
                    r_carry[k] <= w_seg_cout[k-1];
                    r_sat[k]   <= r_sat[k-1];
                end
            end

            r_out_valid <= r_valid[LAST];
            if (r_valid[LAST]) begin
                r_sum      <= w_final_sum;
                r_overflow <= w_ovf;
                r_cout     <= w_seg_cout[LAST];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign overflow  = r_overflow;
    assign cout      = r_cout;

endmodule

// File: tb/tb_signed_pipe_addsub.sv
// -----------------------------------------------------------------------------
// tb_signed_pipe_addsub
// Self-checking bench: a 16-bit/4-stage instance and a 4-bit single-stage
// instance. Accepted beats are turned into expected results by an arithmetic
// reference model; output transfers are collected and compared in order.
// -----------------------------------------------------------------------------
module tb_signed_pipe_addsub;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, op_sub, sat_en, out_ready;
    logic [W-1:0]  a, b;
    logic          in_ready, out_valid, overflow, cout;
    logic [W-1:0]  sum;

    logic          in_valid4, op_sub4, sat_en4, out_ready4;
    logic [3:0]    a4, b4;
    logic          in_ready4, out_valid4, overflow4, cout4;
    logic [3:0]    sum4;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [W-1:0] s;
        logic         o;
        logic         c;
    } res_t;

    res_t exp_q[$];
    res_t got_q[$];

    always #5 clk = ~clk;

    signed_pipe_addsub #(.WIDTH(16), .SEG(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_sub(op_sub), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .overflow(overflow), .cout(cout)
    );

    signed_pipe_addsub #(.WIDTH(4), .SEG(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .op_sub(op_sub4), .sat_en(sat_en4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .overflow(overflow4), .cout(cout4)
    );

    // Reference: exact signed arithmetic, range check for overflow, raw
    // carry from the unsigned sum with effective B and carry-in.
    function automatic res_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                   input logic fsub, input logic fsat);
        res_t        r;
        longint      sa;
        longint      sb;
        longint      full;
        logic [W:0]  u;
        sa   = longint'($signed(fa));
        sb   = longint'($signed(fb));
        full = fsub ? (sa - sb) : (sa + sb);
        u    = {1'b0, fa} + {1'b0, (fsub ? ~fb : fb)} + (W+1)'(fsub);
        r.o  = (full > 32767) || (full < -32768);
        r.c  = u[W];
        if (r.o && fsat) r.s = (full > 0) ? 16'h7FFF : 16'h8000;
        else             r.s = full[W-1:0];
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready)   exp_q.push_back(model(a, b, op_sub, sat_en));
            if (out_valid && out_ready) got_q.push_back(res_t'({sum, overflow, cout}));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; sat_en = 1'b0; out_ready = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; op_sub4 = 1'b0; sat_en4 = 1'b0; out_ready4 = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || sum !== 16'h0 || overflow !== 1'b0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b sum=%h ovf=%b cout=%b, want 0 0000 0 0",
                     out_valid, sum, overflow, cout);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        checks++;
        if (out_valid4 !== 1'b0 || sum4 !== 4'h0 || in_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_w4: got valid=%b sum=%h ready=%b, want 0 0 1",
                     out_valid4, sum4, in_ready4);
        end
        $display("test_reset done");
    endtask

    // Directed corner cases with hand-derived results; also measures latency.
    task automatic test_directed();
        logic [W-1:0] ta [10] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'hFFFF,
                                  16'h00FF, 16'h00FF, 16'h8000, 16'h0000, 16'h0000};
        logic [W-1:0] tb [10] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001,
                                  16'h0F01, 16'h0001, 16'h8000, 16'h8000, 16'h8000};
        logic         tsub[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic         tsat[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] es  [10] = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h0000,
                                  16'h1000, 16'h0100, 16'h0000, 16'h7FFF, 16'h8000};
        logic         eo  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic         ec  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; a = ta[i]; b = tb[i]; op_sub = tsub[i]; sat_en = tsat[i];
            cycle();
            in_valid = 1'b0; a = '0; b = '0;
            lat = 0;
            while (!out_valid && lat < 20) begin
                cycle();
                lat++;
            end
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d cycles want 4", i, lat);
            end
            checks++;
            if (sum !== es[i] || overflow !== eo[i] || cout !== ec[i]) begin
                errors++;
                $display("FAIL dir%0d_result: %h %s %h sat=%b got sum=%h ovf=%b cout=%b want sum=%h ovf=%b cout=%b",
                         i, ta[i], tsub[i] ? "-" : "+", tb[i], tsat[i],
                         sum, overflow, cout, es[i], eo[i], ec[i]);
            end
            cycle();
            $display("directed %0d: %h %s %h sat=%b -> sum=%h ovf=%b cout=%b",
                     i, ta[i], tsub[i] ? "-" : "+", tb[i], tsat[i], es[i], eo[i], ec[i]);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    // Eight beats back to back with alternating op_sub and a 3-cycle stall.
    task automatic test_back_to_back();
        logic [W-1:0] va [8];
        logic [W-1:0] vb [8];
        logic [W-1:0] prev_sum;
        logic         prev_ovf;
        logic         hold;
        int           sent = 0;
        for (int i = 0; i < 8; i++) begin
            va[i] = W'($urandom);
            vb[i] = W'($urandom);
        end
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 30; i++) begin
            out_ready = !(i >= 6 && i < 9);
            in_valid  = (sent < 8);
            a = va[sent % 8]; b = vb[sent % 8];
            op_sub = (sent % 2 == 1);
            sat_en = 1'($urandom);
            #1;
            if (!out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_stall_in_ready cycle %0d: got %b want 0", i, in_ready);
                end
            end
            if (in_valid && in_ready) sent++;
            prev_sum = sum;
            prev_ovf = overflow;
            hold     = out_valid && !out_ready;
            cycle();
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || sum !== prev_sum || overflow !== prev_ovf) begin
                    errors++;
                    $display("FAIL b2b_stall_hold cycle %0d: got valid=%b sum=%h ovf=%b want 1 %h %b",
                             i, out_valid, sum, overflow, prev_sum, prev_ovf);
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got_q.size() !== 8 || exp_q.size() !== 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d results for %0d accepted beats, want 8 and 8",
                     got_q.size(), exp_q.size());
        end
        for (int i = 0; i < 8 && i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_beat%0d: got sum=%h ovf=%b cout=%b want sum=%h ovf=%b cout=%b",
                         i, got_q[i].s, got_q[i].o, got_q[i].c, exp_q[i].s, exp_q[i].o, exp_q[i].c);
            end
            $display("b2b beat %0d: sum=%h ovf=%b cout=%b", i, got_q[i].s, got_q[i].o, got_q[i].c);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    // Random valid/ready traffic with biased corner operands.
    task automatic test_random_stream();
        logic [W-1:0] corners [6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h00FF};
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 200; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            a = ($urandom_range(2) == 0) ? corners[$urandom_range(5)] : W'($urandom);
            b = ($urandom_range(2) == 0) ? corners[$urandom_range(5)] : W'($urandom);
            op_sub = 1'($urandom);
            sat_en = 1'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d results want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_beat%0d: got sum=%h ovf=%b cout=%b want sum=%h ovf=%b cout=%b",
                         i, got_q[i].s, got_q[i].o, got_q[i].c, exp_q[i].s, exp_q[i].o, exp_q[i].c);
            end
        end
        $display("random stream: %0d beats compared", got_q.size());
        exp_q.delete();
        got_q.delete();
    endtask

    // Reset with three beats in flight; nothing stale may emerge afterwards.
    task automatic test_reset_midflight();
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 16'h1111 * W'(i + 1); b = 16'h0101; op_sub = 1'b0; sat_en = 1'b0;
            cycle();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || sum !== 16'h0 || overflow !== 1'b0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got valid=%b sum=%h ovf=%b cout=%b want 0 0000 0 0",
                     out_valid, sum, overflow, cout);
        end
        for (int i = 0; i < 6; i++) begin
            cycle();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_stale cycle %0d: got out_valid=%b want 0", i, out_valid);
            end
        end
        in_valid = 1'b1; a = 16'h1234; b = 16'h0F0F; op_sub = 1'b1; sat_en = 1'b0;
        cycle();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            cycle();
            lat++;
        end
        checks++;
        if (lat !== 4 || sum !== 16'h0325 || overflow !== 1'b0 || cout !== 1'b1) begin
            errors++;
            $display("FAIL midreset_first_beat: got lat=%0d sum=%h ovf=%b cout=%b want 4 0325 0 1",
                     lat, sum, overflow, cout);
        end
        $display("reset midflight: first beat after reset sum=%h latency=%0d", sum, lat);
        cycle();
        exp_q.delete();
        got_q.delete();
    endtask

    // Single-stage instance: WIDTH=SEG=4.
    task automatic test_single_stage();
        logic [3:0] ta [2] = '{4'h7, 4'h8};
        logic [3:0] tb [2] = '{4'h1, 4'h8};
        logic [3:0] es [2] = '{4'h8, 4'h0};
        logic       eo [2] = '{1'b1, 1'b1};
        logic       ec [2] = '{1'b0, 1'b1};
        int lat;
        out_ready4 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid4 = 1'b1; a4 = ta[i]; b4 = tb[i]; op_sub4 = 1'b0; sat_en4 = 1'b0;
            cycle();
            in_valid4 = 1'b0;
            lat = 0;
            while (!out_valid4 && lat < 10) begin
                cycle();
                lat++;
            end
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL w4_%0d_latency: got %0d want 1", i, lat);
            end
            checks++;
            if (sum4 !== es[i] || overflow4 !== eo[i] || cout4 !== ec[i]) begin
                errors++;
                $display("FAIL w4_%0d_result: got sum=%h ovf=%b cout=%b want sum=%h ovf=%b cout=%b",
                         i, sum4, overflow4, cout4, es[i], eo[i], ec[i]);
            end
            $display("single stage %0d: %h + %h -> sum=%h ovf=%b cout=%b", i, ta[i], tb[i], sum4, overflow4, cout4);
            cycle();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random_stream();
        test_reset_midflight();
        test_single_stage();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
